// File: rtl/par2ser.sv
// Parallel-to-serial converter: captures a PW-bit packet and emits it SW bits at a time, LSB- or MSB-word first.
// Optional framing outputs (first/last) are present when PAR2SER_FRAME_EN is defined.
module par2ser #(
    parameter int PW = 64,
    parameter int SW = 1,
    parameter int CW = $clog2(PW / SW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [PW-1:0] din,
    input  logic          load,
    input  logic [CW:0]   datasize,
    input  logic          lsbfirst,
    input  logic          shift,
    output logic [SW-1:0] dout,
    output logic          valid,
`ifdef PAR2SER_FRAME_EN
    output logic          first,
    output logic          last,
`endif
    output logic          ready
);

    localparam int NW = PW / SW;
    localparam logic [CW:0] NWC = (CW + 1)'(NW);
    localparam logic [CW:0] ONE = (CW + 1)'(1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] sreg_q, sreg_d;
    logic [CW:0]   count_q, count_d;
    logic          lsb_q, lsb_d;
    logic [CW:0]   eff_size;
    logic          final_shift;
    logic          accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            count_q <= '0;
            lsb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            count_q <= count_d;
            lsb_q   <= lsb_d;
        end
    end

    // ready depends combinationally on shift so the final word and the next load can share a cycle
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        count_d     = count_q;
        lsb_d       = lsb_q;
        eff_size    = (datasize == '0 || datasize > NWC) ? NWC : datasize;
        final_shift = (state_q == ACTIVE) && shift && (count_q == ONE);
        ready       = (state_q == IDLE) || final_shift;
        accept      = load && ready;

        if (state_q == ACTIVE && shift) begin
            sreg_d  = lsb_q ? (sreg_q >> SW) : (sreg_q << SW);
            count_d = count_q - ONE;
            if (final_shift) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            sreg_d  = din;
            lsb_d   = lsbfirst;
            count_d = eff_size;
            state_d = ACTIVE;
        end
    end

    assign valid = (state_q == ACTIVE);
    assign dout  = lsb_q ? sreg_q[SW-1:0] : sreg_q[PW-1 -: SW];

`ifdef PAR2SER_FRAME_EN
    logic first_q, first_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            first_q <= 1'b0;
        end else begin
            first_q <= first_d;
        end
    end

    always_comb begin
        first_d = first_q;
        if (state_q == ACTIVE && shift) begin
            first_d = 1'b0;
        end
        if (accept) begin
            first_d = 1'b1;
        end
    end

    assign first = valid && first_q;
    assign last  = valid && (count_q == ONE);
`endif

endmodule

// File: tb/tb_par2ser.sv
// Directed bench for par2ser (PW=16, SW=4) with a queue-based packet model checked every cycle.
// Define PAR2SER_FRAME_EN for both files to also exercise first/last.
module tb_par2ser;

    localparam int PW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] din;
    logic          load;
    logic [2:0]    datasize;
    logic          lsbfirst;
    logic          shift;
    logic [SW-1:0] dout;
    logic          valid;
    logic          ready;
`ifdef PAR2SER_FRAME_EN
    logic          first;
    logic          last;
`endif

    int checks = 0;
    int errors = 0;

    par2ser #(.PW(PW), .SW(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .load     (load),
        .datasize (datasize),
        .lsbfirst (lsbfirst),
        .shift    (shift),
        .dout     (dout),
        .valid    (valid),
`ifdef PAR2SER_FRAME_EN
        .first    (first),
        .last     (last),
`endif
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the packet is a queue of words still to be emitted
    logic [3:0] mq[$];
    int         pos   = 0;
    bit         zflag = 1'b0;
    bit         live  = 1'b0;
    logic [3:0] slog[$];
    logic [3:0] vlog[$];
    logic [3:0] rlog[$];
    logic [3:0] flog[$];

    always @(negedge clk) begin
        int  n;
        bit  rdy;
        if (live) begin
            chk("valid", {31'b0, valid}, {31'b0, mq.size() > 0});
            chk("ready", {31'b0, ready}, {31'b0, (mq.size() == 0) || (mq.size() == 1 && shift)});
            if (mq.size() > 0) chk("dout", {28'b0, dout}, {28'b0, mq[0]});
            else if (zflag) chk("dout_after_reset", {28'b0, dout}, 32'h0);
`ifdef PAR2SER_FRAME_EN
            chk("first", {31'b0, first}, {31'b0, mq.size() > 0 && pos == 0});
            chk("last", {31'b0, last}, {31'b0, mq.size() == 1});
            if (valid) flog.push_back({2'b0, first, last});
`endif
            if (valid) vlog.push_back(dout);
            if (valid && shift) begin
                slog.push_back(dout);
                rlog.push_back({3'b0, ready});
            end
        end
        if (reset) begin
            mq.delete();
            pos   = 0;
            zflag = 1'b1;
            live  = 1'b1;
        end else if (live) begin
            rdy = (mq.size() == 0) || (mq.size() == 1 && shift);
            if (mq.size() > 0 && shift) begin
                void'(mq.pop_front());
                pos++;
            end
            if (load && rdy) begin
                n = (datasize == 0 || datasize > 4) ? 4 : int'(datasize);
                for (int i = 0; i < n; i++)
                    mq.push_back(lsbfirst ? din[i*4 +: 4] : din[12 - 4*i +: 4]);
                pos   = 0;
                zflag = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pkt(input logic [15:0] d, input logic [2:0] ds, input logic lsb);
        din      = d;
        datasize = ds;
        lsbfirst = lsb;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic clear_logs();
        slog.delete();
        vlog.delete();
        rlog.delete();
        flog.delete();
    endtask

    task automatic chk_seq(input string name, input logic [3:0] act[$], input logic [3:0] exp[$]);
        chk({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk(name, {28'b0, act[i]}, {28'b0, exp[i]});
    endtask

    logic [3:0] e[$];

    initial begin
        reset = 1'b1; din = '0; load = 1'b0; datasize = '0; lsbfirst = 1'b0; shift = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_valid", {31'b0, valid}, 32'd0);
        chk("reset_ready", {31'b0, ready}, 32'd1);
        chk("reset_dout", {28'b0, dout}, 32'd0);

        // reset mid-packet discards the partial packet
        load_pkt(16'hABCD, 3'd0, 1'b0);
        shift = 1'b1;
        tick(); tick();
        chk("mid_dout_before_reset", {28'b0, dout}, 32'hC);
        reset = 1'b1; shift = 1'b0;
        tick();
        reset = 1'b0;
        chk("midreset_valid", {31'b0, valid}, 32'd0);
        chk("midreset_ready", {31'b0, ready}, 32'd1);
        chk("midreset_dout", {28'b0, dout}, 32'd0);
        tick();

        // lsb-first full packet; lsbfirst change mid-packet has no effect
        load_pkt(16'hABCD, 3'd0, 1'b1);
        lsbfirst = 1'b0;
        clear_logs();
        shift = 1'b1;
        repeat (4) tick();
        shift = 1'b0;
        chk("lsb_done_valid", {31'b0, valid}, 32'd0);
        e = '{4'hD, 4'hC, 4'hB, 4'hA};
        chk_seq("lsb_words", slog, e);
        e = '{4'h0, 4'h0, 4'h0, 4'h1};
        chk_seq("lsb_ready", rlog, e);
        tick();

        // short packet, extra shifts in IDLE ignored
        load_pkt(16'h1234, 3'd2, 1'b0);
        clear_logs();
        shift = 1'b1;
        repeat (4) tick();
        shift = 1'b0;
        e = '{4'h1, 4'h2};
        chk_seq("short_words", slog, e);
        tick();

        // back-to-back packets
        load_pkt(16'h1111, 3'd0, 1'b0);
        clear_logs();
        shift = 1'b1;
        repeat (3) tick();
        din = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        shift = 1'b0;
        e = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2};
        chk_seq("b2b_words", vlog, e);
        e = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
        chk_seq("b2b_ready", rlog, e);
        tick();

        // stall and ignored load
        load_pkt(16'hABCD, 3'd0, 1'b0);
        clear_logs();
        din = 16'hFFFF; load = 1'b1;
        shift = 1'b1; tick();
        shift = 1'b0; tick();
        shift = 1'b1; tick();
        load = 1'b0;
        tick(); tick();
        shift = 1'b0;
        e = '{4'hA, 4'hB, 4'hB, 4'hC, 4'hD};
        chk_seq("stall_words", vlog, e);
        tick();

        // oversize datasize clamps to 4 words
        load_pkt(16'h5A3C, 3'd5, 1'b1);
        clear_logs();
        shift = 1'b1;
        repeat (4) tick();
        shift = 1'b0;
        e = '{4'hC, 4'h3, 4'hA, 4'h5};
        chk_seq("clamp_words", slog, e);
        tick();

        // single-word packet
        load_pkt(16'h0007, 3'd1, 1'b1);
        clear_logs();
        shift = 1'b1;
        tick();
        shift = 1'b0;
        e = '{4'h7};
        chk_seq("single_words", slog, e);
        e = '{4'h1};
        chk_seq("single_ready", rlog, e);
        tick();

        // framing flags over a 4-word packet: {first,last}
        load_pkt(16'h9876, 3'd0, 1'b0);
        clear_logs();
        shift = 1'b1;
        repeat (4) tick();
        shift = 1'b0;
        e = '{4'h9, 4'h8, 4'h7, 4'h6};
        chk_seq("frame_words", slog, e);
`ifdef PAR2SER_FRAME_EN
        e = '{4'h2, 4'h0, 4'h0, 4'h1};
        chk_seq("frame_flags", flog, e);
`endif
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/par2ser.md
PAR2SER -- requirements
Module: par2ser

Interface
REQ-001 Parameter PW, default 64: parallel packet width in bits.
REQ-002 Parameter SW, default 1: serial word width in bits; PW SHALL be an integer multiple of SW.
REQ-003 Parameter CW, default $clog2(PW/SW): serialization counter width.
REQ-004 clk  input  1: sampling clock; all state updates on its rising edge.
REQ-005 reset  input  1: one clock; reset is synchronous and active-high.
REQ-006 din  input  PW: parallel data to serialize.
REQ-007 load  input  1: request to capture din; accepted only when ready=1.
REQ-008 datasize  input  CW+1: number of SW-wide words to emit (1..PW/SW); 0 means PW/SW.
REQ-009 lsbfirst  input  1: 1 = least significant word first; 0 = most significant word first.
REQ-010 shift  input  1: advance the serializer by one word this cycle.
REQ-011 dout  output  SW: current serial word.
REQ-012 valid  output  1: dout holds a word of the active packet.
REQ-013 ready  output  1: block accepts load this cycle.

Function
REQ-014 Two states: IDLE and ACTIVE.
REQ-015 IDLE: valid=0, ready=1; load=1 captures din into shift register, captures lsbfirst, sets count to the effective datasize, enters ACTIVE next cycle.
REQ-016 ACTIVE: valid=1; dout = shiftreg[SW-1:0] when captured lsbfirst=1, else shiftreg[PW-1:PW-SW] (combinational from register, zero added latency).
REQ-017 ACTIVE with shift=1: shiftreg shifts right by SW (lsbfirst) or left by SW (msbfirst), zero fill; count decrements by 1.
REQ-018 ACTIVE with shift=0: shiftreg, count, state hold.
REQ-019 ready=1 in ACTIVE only when count=1 and shift=1 (final word consumed this cycle).
REQ-020 Final word consumed and load=1 same cycle: new packet captured, state stays ACTIVE, no idle bubble.
REQ-021 Final word consumed and load=0: state returns to IDLE next cycle.
REQ-022 load while ready=0: ignored, no state change.
REQ-023 lsbfirst changes during ACTIVE: no effect until next accepted load.
REQ-024 shift in IDLE: ignored.
REQ-025 datasize > PW/SW: treated as PW/SW.
REQ-026 First word appears on dout the cycle after load accepted; packet of N words completes after N shift cycles.

Reset
REQ-027 reset=1 at a rising edge: state=IDLE, count=0, shiftreg=0, captured lsbfirst=0; next cycle dout=0, valid=0, ready=1.
REQ-028 reset has priority over load and shift in the same cycle, including mid-packet; the partial packet is discarded.

Configuration
REQ-029 Macro PAR2SER_FRAME_EN defined: outputs first (1 bit, high while the first word of a packet is on dout with valid=1) and last (1 bit, high while count=1 with valid=1) are present, both reset to 0.
REQ-030 PAR2SER_FRAME_EN undefined: first and last ports do not exist; all other behaviour identical.

Verification (bench PW=16, SW=4)
REQ-031 Reset mid-packet: load din=0xABCD, 2 shifts, assert reset -> next cycle valid=0, ready=1, dout=0.
REQ-032 lsbfirst=1, load 0xABCD, datasize=0, shift held high -> dout D,C,B,A over 4 cycles, ready=1 only in 4th, then valid=0.
REQ-033 lsbfirst=0, load 0x1234, datasize=2, shift high -> dout 1,2, then IDLE; words 3,4 never emitted.
REQ-034 Back-to-back: load 0x1111 then load 0x2222 on the final-shift cycle -> dout 1,1,1,1,2,2,2,2 with valid continuously 1.
REQ-035 Stall and ignored load: load 0xABCD msbfirst, shift toggled 1,0,1 with load=1 and din=0xFFFF during ACTIVE -> dout A,B,B,C; 0xFFFF never captured.
REQ-036 With PAR2SER_FRAME_EN: 4-word packet -> first=1 on word 1 only, last=1 on word 4 only.
